prio_enc8to3: RTL and testbench

Registered 8-to-3 priority encoder with enable and valid flag. Reports the index of the highest-numbered asserted bit of an 8-bit request vector, and flags whether any bit was asserted. It sits between request/interrupt-style sources and downstream select/arbitration logic that needs a stable, clocked index.

---
 rtl/prio_enc_pkg.sv | 13 +
 rtl/prio_enc8to3_core.sv | 28 ++
 rtl/prio_enc8to3.sv | 35 +++
 tb/tb_prio_enc8to3.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/prio_enc_pkg.sv
// Shared widths, types and reset values for the 8-to-3 priority encoder.
package prio_enc_pkg;

  localparam int DIN_W = 8;
  localparam int Y_W   = $clog2(DIN_W);

  typedef logic [DIN_W-1:0] din_t;
  typedef logic [Y_W-1:0]   idx_t;

  localparam idx_t Y_RST     = '0;
  localparam logic VALID_RST = 1'b0;

endpackage : prio_enc_pkg

// File: rtl/prio_enc8to3_core.sv
// Combinational priority scan: index of the highest set request bit, gated by EN.
module prio_enc8to3_core
  import prio_enc_pkg::*;
(
  input  din_t Din,
  input  logic EN,
  output idx_t next_Y,
  output logic next_valid
);

  // NOTE: combinational blocks use blocking assignments and assign every output
  // a default first, so no path leaves a value held and no latch is inferred.
  always_comb begin
    next_Y     = Y_RST;
    next_valid = VALID_RST;
    if (EN) begin
      // Scanning downward, next_valid doubles as the "already found" flag so the
      // first (highest) set bit wins and lower bits are ignored.
      for (int i = DIN_W - 1; i >= 0; i--) begin
        if (Din[i] && !next_valid) begin
          next_Y     = idx_t'(i);
          next_valid = 1'b1;
        end
      end
    end
  end

endmodule : prio_enc8to3_core

// File: rtl/prio_enc8to3.sv
// Registered 8-to-3 priority encoder with enable and valid qualifier.
module prio_enc8to3
  import prio_enc_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  din_t Din,
  input  logic EN,
  output idx_t Y,
  output logic valid
);

  idx_t next_Y;
  logic next_valid;

  prio_enc8to3_core u_core (
    .Din        (Din),
    .EN         (EN),
    .next_Y     (next_Y),
    .next_valid (next_valid)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement or process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y     <= Y_RST;
      valid <= VALID_RST;
    end else begin
      Y     <= next_Y;
      valid <= next_valid;
    end
  end

endmodule : prio_enc8to3

// File: tb/tb_prio_enc8to3.sv
// Directed self-checking bench for prio_enc8to3: reset, gating, priority and latency.
module tb_prio_enc8to3;
  import prio_enc_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  din_t Din;
  logic EN;
  idx_t Y;
  logic valid;

  int checks   = 0;
  int failures = 0;

  prio_enc8to3 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .Din   (Din),
    .EN    (EN),
    .Y     (Y),
    .valid (valid)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Independent reference: position of the highest set bit by repeated shifting.
  function automatic idx_t ref_y(input din_t d, input logic en);
    int   idx;
    din_t tmp;
    idx = 0;
    tmp = d;
    if (!en) return '0;
    while (tmp > 1) begin
      tmp = tmp >> 1;
      idx++;
    end
    return idx_t'(idx);
  endfunction

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    Din   = 8'hFF;
    EN    = 1'b1;
    #1;
    checks++;
    if (Y !== 3'd0 || valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_immediate: Y=%0d valid=%b, want Y=0 valid=0", Y, valid);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (Y !== 3'd0 || valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold[%0d]: Y=%0d valid=%b, want Y=0 valid=0", k, Y, valid);
      end
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (Y !== 3'd0 || valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_pre_edge: Y=%0d valid=%b, want Y=0 valid=0", Y, valid);
    end
    step();
    checks++;
    if (Y !== 3'd7 || valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_edge: Y=%0d valid=%b, want Y=7 valid=1", Y, valid);
    end
  endtask

  task automatic test_disabled();
    EN = 1'b0;
    for (int i = 0; i < 256; i++) begin
      Din = din_t'(i);
      step();
      checks++;
      if (Y !== 3'd0 || valid !== 1'b0) begin
        failures++;
        $display("FAIL disabled[Din=%02h]: Y=%0d valid=%b, want Y=0 valid=0", Din, Y, valid);
      end
    end
  endtask

  task automatic test_onehot();
    EN  = 1'b1;
    Din = 8'h00;
    step();
    checks++;
    if (Y !== 3'd0 || valid !== 1'b0) begin
      failures++;
      $display("FAIL empty: Y=%0d valid=%b, want Y=0 valid=0", Y, valid);
    end
    for (int k = 0; k < 8; k++) begin
      Din = din_t'(1) << k;
      #2;
      // Between edges the previous result must still be showing.
      checks++;
      if (k > 0 && (Y !== idx_t'(k - 1) || valid !== 1'b1)) begin
        failures++;
        $display("FAIL onehot_hold[%0d]: Y=%0d valid=%b, want Y=%0d valid=1", k, Y, valid, k - 1);
      end else if (k == 0 && (Y !== 3'd0 || valid !== 1'b0)) begin
        failures++;
        $display("FAIL onehot_hold[0]: Y=%0d valid=%b, want Y=0 valid=0", Y, valid);
      end
      step();
      checks++;
      if (Y !== idx_t'(k) || valid !== 1'b1) begin
        failures++;
        $display("FAIL onehot[%0d]: Y=%0d valid=%b, want Y=%0d valid=1", k, Y, valid, k);
      end
    end
  endtask

  task automatic test_multibit();
    din_t vec [3] = '{8'b1010_0101, 8'b0011_1111, 8'b0000_0110};
    idx_t exp [3] = '{3'd7, 3'd5, 3'd2};
    EN = 1'b1;
    for (int k = 0; k < 3; k++) begin
      Din = vec[k];
      step();
      checks++;
      if (Y !== exp[k] || valid !== 1'b1) begin
        failures++;
        $display("FAIL multibit[Din=%08b]: Y=%0d valid=%b, want Y=%0d valid=1",
                 vec[k], Y, valid, exp[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    EN  = 1'b1;
    Din = 8'h80;
    step();
    EN  = 1'b0;
    Din = 8'h40;
    step();
    checks++;
    if (Y !== 3'd0 || valid !== 1'b0) begin
      failures++;
      $display("FAIL en_fall_with_din_change: Y=%0d valid=%b, want Y=0 valid=0", Y, valid);
    end
    EN = 1'b1;
    step();
    checks++;
    if (Y !== 3'd6 || valid !== 1'b1) begin
      failures++;
      $display("FAIL en_rise: Y=%0d valid=%b, want Y=6 valid=1", Y, valid);
    end
  endtask

  task automatic test_exhaustive();
    idx_t exp_y;
    logic exp_v;
    EN = 1'b1;
    for (int i = 0; i < 256; i++) begin
      Din   = din_t'(i);
      exp_y = ref_y(din_t'(i), 1'b1);
      exp_v = (i != 0);
      step();
      checks++;
      if (Y !== exp_y || valid !== exp_v) begin
        failures++;
        $display("FAIL exhaustive[Din=%02h]: Y=%0d valid=%b, want Y=%0d valid=%b",
                 i, Y, valid, exp_y, exp_v);
      end
    end
  endtask

  task automatic test_midstream_reset();
    idx_t exp_y;
    EN = 1'b1;
    for (int i = 200; i < 216; i++) begin
      Din   = din_t'(i);
      exp_y = ref_y(din_t'(i), 1'b1);
      step();
      checks++;
      if (Y !== exp_y || valid !== 1'b1) begin
        failures++;
        $display("FAIL midstream[Din=%02h]: Y=%0d valid=%b, want Y=%0d valid=1", i, Y, valid, exp_y);
      end
      if (i == 207) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if (Y !== 3'd0 || valid !== 1'b0) begin
          failures++;
          $display("FAIL midstream_async_clear: Y=%0d valid=%b, want Y=0 valid=0", Y, valid);
        end
        #2;
        rst_n = 1'b1;
        #1;
        checks++;
        if (Y !== 3'd0 || valid !== 1'b0) begin
          failures++;
          $display("FAIL midstream_release_pre_edge: Y=%0d valid=%b, want Y=0 valid=0", Y, valid);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_disabled();
    test_onehot();
    test_multibit();
    test_back_to_back();
    test_exhaustive();
    test_midstream_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_prio_enc8to3
